// File: rtl/cap_sense_pkg.sv
// Shared types for the capacitive sense front end: channel and scan state
// encodings plus the saturation value helper.
package cap_sense_pkg;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_CHARGE,
        CH_MEASURE,
        CH_FIN
    } ch_state_t;

    typedef enum logic {
        IDLE,
        SCAN
    } top_state_t;

    // All-ones value of a w-bit counter; the discharge counter saturates here.
    function automatic int count_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/cap_sense_array_if.sv
// Control/status bundle between the game logic and the sense array.
// master = game logic side, slave = cap_sense_array.
interface cap_sense_array_if #(
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 16
);
    logic                        start;
    logic [COUNT_W-1:0]          threshold;
    logic                        busy;
    logic                        done;
    logic [NUM_CH*COUNT_W-1:0]   final_count;
    logic [NUM_CH-1:0]           valid;
    logic [NUM_CH-1:0]           touched;
    logic [NUM_CH-1:0]           timeout;

    modport master (
        output start, threshold,
        input  busy, done, final_count, valid, touched, timeout
    );

    modport slave (
        input  start, threshold,
        output busy, done, final_count, valid, touched, timeout
    );
endinterface

// File: rtl/cap_sense_channel.sv
// One sense channel: input synchroniser, charge timer, discharge counter,
// result latch and touch decision.
// Optional baseline tracking is built when CAP_SENSE_BASELINE_EN is defined.
//
// state      | meaning
// CH_IDLE    | waiting for a scan launch
// CH_CHARGE  | charge_out high, timer counting down CHARGE_CYCLES
// CH_MEASURE | counting cycles while the synchronised sensor is high
// CH_FIN     | result latched, waiting for the scan to close
module cap_sense_channel
    import cap_sense_pkg::*;
#(
    parameter int COUNT_W       = 16,
    parameter int CHARGE_CYCLES = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int BASE_SHIFT    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               launch,
    input  logic               scan_active,
    input  logic               sensor_in,
    input  logic [COUNT_W-1:0] threshold,
    output logic               charge_out,
    output logic               fin,
    output logic [COUNT_W-1:0] final_count,
    output logic               valid,
    output logic               touched,
    output logic               timeout
);

    localparam int TMR_W = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
    localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(CHARGE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(count_max(COUNT_W));

    if (SYNC_STAGES < 2 || CHARGE_CYCLES < 1 || BASE_SHIFT < 0 || BASE_SHIFT > COUNT_W) begin : g_bad_param
        $error("cap_sense_channel: illegal parameter value");
    end

    ch_state_t              state;
    logic [TMR_W-1:0]       timer;
    logic [COUNT_W-1:0]     count;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [COUNT_W-1:0]     latch_val;
    logic                   new_touch;

    assign sync = sync_q[SYNC_STAGES-1];
    assign fin  = (state == CH_FIN);

    // A latch is either a natural end (count so far) or a saturation (all ones).
    assign latch_val = sync ? COUNT_MAX : count;

    // Shift-register synchroniser for the asynchronous sense pin.
    always_ff @(posedge clock) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_in};
    end

`ifdef CAP_SENSE_BASELINE_EN
    logic [COUNT_W-1:0]        baseline;
    logic                      base_loaded;
    logic [COUNT_W-1:0]        new_base;
    logic signed [COUNT_W:0]   delta;
    logic signed [COUNT_W:0]   step;

    // Touch decision relative to the tracked baseline; baseline only drifts
    // toward untouched readings so a held finger does not get absorbed.
    always_comb begin
        delta = $signed({1'b0, latch_val}) - $signed({1'b0, baseline});
        step  = delta >>> BASE_SHIFT;
        if (!base_loaded) begin
            new_touch = 1'b0;
            new_base  = latch_val;
        end else begin
            new_touch = (latch_val > baseline) && ((latch_val - baseline) > threshold);
            new_base  = new_touch ? baseline : COUNT_W'($signed({1'b0, baseline}) + step);
        end
    end

    // Baseline storage, updated only on accepted (non-zero) latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            baseline    <= '0;
            base_loaded <= 1'b0;
        end else if (state == CH_MEASURE && (sync ? (count == COUNT_MAX - 1'b1) : (count != '0))) begin
            baseline    <= new_base;
            base_loaded <= 1'b1;
        end
    end
`else
    // Absolute threshold compare.
    always_comb new_touch = (latch_val > threshold);
`endif

    // Channel sequencing: charge, measure, latch, then park until the scan closes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= CH_IDLE;
            timer       <= '0;
            count       <= '0;
            charge_out  <= 1'b0;
            final_count <= '0;
            valid       <= 1'b0;
            touched     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                CH_IDLE, CH_FIN: begin
                    if (launch) begin
                        state      <= CH_CHARGE;
                        charge_out <= 1'b1;
                        timer      <= TMR_LOAD;
                        count      <= '0;
                    end else if (state == CH_FIN && !scan_active) begin
                        state <= CH_IDLE;
                    end
                end
                CH_CHARGE: begin
                    if (timer == '0) begin
                        state      <= CH_MEASURE;
                        charge_out <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                CH_MEASURE: begin
                    if (!sync) begin
                        state   <= CH_FIN;
                        timeout <= 1'b0;
                        if (count != '0) begin
                            final_count <= latch_val;
                            valid       <= 1'b1;
                            touched     <= new_touch;
                        end
                    end else if (count == COUNT_MAX - 1'b1) begin
                        state       <= CH_FIN;
                        final_count <= latch_val;
                        valid       <= 1'b1;
                        timeout     <= 1'b1;
                        touched     <= new_touch;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= CH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cap_sense_array.sv
// Multi-channel capacitive touch front end: one scan FSM launching NUM_CH
// lockstep sense channels and packing their results onto the status bus.
// Optional baseline tracking: define CAP_SENSE_BASELINE_EN.
//
// state | meaning
// IDLE  | no scan running, start accepted
// SCAN  | channels running, waiting for all to finish
module cap_sense_array
    import cap_sense_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int COUNT_W       = 16,
    parameter int CHARGE_CYCLES = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int BASE_SHIFT    = 3
) (
    input  logic                clock,
    input  logic                reset,
    cap_sense_array_if.slave    bus,
    input  logic [NUM_CH-1:0]   sensor_in,
    output logic [NUM_CH-1:0]   charge_out
);

    top_state_t                state;
    logic                      busy_q;
    logic                      done_q;
    logic                      launch;
    logic                      scan_active;
    logic [NUM_CH-1:0]         ch_fin;
    logic [NUM_CH*COUNT_W-1:0] ch_count;
    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH-1:0]         ch_touched;
    logic [NUM_CH-1:0]         ch_timeout;

    assign launch      = (state == IDLE) && bus.start;
    assign scan_active = (state == SCAN);

    // Scan FSM: accepts start only when idle, closes once every channel is parked.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SCAN;
                        busy_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (&ch_fin) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cap_sense_channel #(
            .COUNT_W       (COUNT_W),
            .CHARGE_CYCLES (CHARGE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .BASE_SHIFT    (BASE_SHIFT)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .launch      (launch),
            .scan_active (scan_active),
            .sensor_in   (sensor_in[i]),
            .threshold   (bus.threshold),
            .charge_out  (charge_out[i]),
            .fin         (ch_fin[i]),
            .final_count (ch_count[i*COUNT_W +: COUNT_W]),
            .valid       (ch_valid[i]),
            .touched     (ch_touched[i]),
            .timeout     (ch_timeout[i])
        );
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.final_count = ch_count;
    assign bus.valid       = ch_valid;
    assign bus.touched     = ch_touched;
    assign bus.timeout     = ch_timeout;

endmodule

// File: tb/tb_cap_sense_array.sv
// Randomised and directed bench for cap_sense_array with a result-level model.
module tb_cap_sense_array;

    localparam int NCH    = 4;
    localparam int CW     = 8;
    localparam int CHARGE = 10;
    localparam int SYNC   = 2;
    localparam int BSHIFT = 3;
    localparam int MAXC   = (1 << CW) - 1;

    logic           clock;
    logic           reset;
    logic [NCH-1:0] sens;
    logic [NCH-1:0] charge_out;

    cap_sense_array_if #(.NUM_CH(NCH), .COUNT_W(CW)) bus ();

    cap_sense_array #(
        .NUM_CH(NCH), .COUNT_W(CW), .CHARGE_CYCLES(CHARGE),
        .SYNC_STAGES(SYNC), .BASE_SHIFT(BSHIFT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .sensor_in  (sens),
        .charge_out (charge_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-scan stimulus: high[i]=0 keeps the pin low (zero count),
    // otherwise the pin drops hold[i] cycles after charge_out falls.
    int hold [NCH];
    bit high [NCH];

    int m_fc    [NCH];
    bit m_valid [NCH];
    bit m_touch [NCH];
    bit m_to    [NCH];
    int m_base  [NCH];
    bit m_loaded[NCH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NCH; i++) begin
            m_fc[i] = 0; m_valid[i] = 0; m_touch[i] = 0; m_to[i] = 0;
            m_base[i] = 0; m_loaded[i] = 0;
        end
    endtask

    // Result-level model: a pin held high for hold cycles past the charge
    // phase is seen for hold+SYNC cycles through the synchroniser.
    task automatic model_scan(input int thr);
        for (int i = 0; i < NCH; i++) begin
            int n;
            int c;
            bit t;
            if (!high[i]) begin
                m_to[i] = 0;
                continue;
            end
            n = hold[i] + SYNC;
            if (n >= MAXC) begin c = MAXC; m_to[i] = 1; end
            else begin c = n; m_to[i] = 0; end
            m_fc[i] = c;
            m_valid[i] = 1;
`ifdef CAP_SENSE_BASELINE_EN
            if (!m_loaded[i]) begin
                m_base[i] = c; m_loaded[i] = 1; t = 0;
            end else begin
                t = (c > m_base[i]) && (c - m_base[i] > thr);
                if (!t) m_base[i] = m_base[i] + ((c - m_base[i]) >>> BSHIFT);
            end
`else
            t = (c > thr);
`endif
            m_touch[i] = t;
        end
    endtask

    task automatic drop(input int k);
        for (int i = 0; i < NCH; i++)
            if (high[i] && hold[i] == k) sens[i] = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("%s_fc%0d", tag, i), bus.final_count[i*CW +: CW], m_fc[i]);
            chk($sformatf("%s_valid%0d", tag, i), bus.valid[i], m_valid[i]);
            chk($sformatf("%s_touch%0d", tag, i), bus.touched[i], m_touch[i]);
            chk($sformatf("%s_tmo%0d", tag, i), bus.timeout[i], m_to[i]);
        end
    endtask

    task automatic run_scan(input string tag, input int thr, input bit extra_start);
        int cyc;
        int charge_cnt;
        int k;
        int extra;
        bit busy_ok;
        bus.threshold = CW'(thr);
        for (int i = 0; i < NCH; i++) sens[i] = high[i];
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc = 0; charge_cnt = 0; busy_ok = 1;
        while (charge_out == '1 && cyc < 100) begin
            charge_cnt++;
            if (!bus.busy) busy_ok = 0;
            if (extra_start) bus.start = (cyc == 3);
            tick;
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, "_charge_len"}, charge_cnt, CHARGE);
        chk({tag, "_busy_charge"}, busy_ok, 1);
        chk({tag, "_charge_off"}, charge_out, 0);
        k = 0;
        drop(0);
        while (!bus.done && k < 2000) begin
            tick;
            k++;
            drop(k);
        end
        chk({tag, "_done_seen"}, bus.done, 1);
        chk({tag, "_busy_at_done"}, bus.busy, 0);
        extra = 0;
        for (int j = 0; j < 4; j++) begin
            tick;
            if (bus.done || bus.busy) extra++;
        end
        chk({tag, "_no_extra"}, extra, 0);
        model_scan(thr);
        check_all(tag);
    endtask

    task automatic all_high_hold(input int h);
        for (int i = 0; i < NCH; i++) begin high[i] = 1; hold[i] = h; end
    endtask

    initial begin
        int budget;
        int dones;
        bit exp_bt [3];
        reset = 1'b1;
        sens = '0;
        bus.start = 1'b0;
        bus.threshold = '0;
        model_reset();
        tick; tick;
        chk("rst_charge", charge_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        check_all("rst");
        reset = 1'b0;
        tick; tick;
        chk("idle_busy", bus.busy, 0);

        // ch0 50 cycles, others 20, with an ignored start during busy
        all_high_hold(20 - SYNC);
        hold[0] = 50 - SYNC;
        run_scan("scanA", 30, 1'b1);
`ifndef CAP_SENSE_BASELINE_EN
        chk("scanA_touched", bus.touched, 4'b0001);
`endif
        chk("scanA_fc0", bus.final_count[0 +: CW], 50);

        // ch2 reaches 40, then a zero-count scan must keep it
        all_high_hold(0);
        for (int i = 0; i < NCH; i++) hold[i] = $urandom_range(40, 0);
        hold[2] = 40 - SYNC;
        run_scan("scanB", 25, 1'b0);
        high[2] = 0;
        run_scan("scanC", 25, 1'b0);
        chk("keep_fc2", bus.final_count[2*CW +: CW], 40);
        chk("keep_valid2", bus.valid[2], 1);

        // ch1 stuck high saturates
        all_high_hold(10);
        hold[1] = 100000;
        run_scan("scanD", 40, 1'b0);
        chk("sat_fc1", bus.final_count[1*CW +: CW], MAXC);
        chk("sat_tmo1", bus.timeout[1], 1);
        all_high_hold(5);
        run_scan("scanE", 40, 1'b0);

        // randomised scans
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NCH; i++) begin
                high[i] = ($urandom_range(5, 0) != 0);
                hold[i] = $urandom_range(70, 0);
            end
            run_scan($sformatf("rnd%0d", r), $urandom_range(80, 0), $urandom_range(1, 0));
        end

        // reset during MEASURE aborts the scan
        all_high_hold(60);
        for (int i = 0; i < NCH; i++) sens[i] = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        budget = 0;
        while (charge_out != 0 && budget < 100) begin tick; budget++; end
        chk("mid_reach_measure", charge_out, 0);
        repeat (5) tick;
        reset = 1'b1;
        tick;
        model_reset();
        chk("mid_charge", charge_out, 0);
        chk("mid_busy", bus.busy, 0);
        check_all("mid");
        reset = 1'b0;
        dones = 0;
        for (int j = 0; j < 40; j++) begin
            tick;
            if (bus.done) dones++;
        end
        chk("mid_no_done", dones, 0);

        // baseline sequence on ch0: counts 100, 108, 130 with threshold 10
        for (int i = 0; i < NCH; i++) begin high[i] = 0; hold[i] = 0; end
        high[0] = 1;
        exp_bt[0] = 0; exp_bt[1] = 0; exp_bt[2] = 1;
        for (int s = 0; s < 3; s++) begin
            hold[0] = (s == 0) ? 100 - SYNC : (s == 1) ? 108 - SYNC : 130 - SYNC;
            run_scan($sformatf("base%0d", s), 10, 1'b0);
`ifdef CAP_SENSE_BASELINE_EN
            chk($sformatf("base%0d_touch_fixed", s), bus.touched[0], exp_bt[s]);
`else
            chk($sformatf("abs%0d_touch_fixed", s), bus.touched[0], 1);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cap_sense_array.md
Name: cap_sense_array

Overview:
Parametrised multi-channel capacitive touch front end. Each channel charges its sense capacitor for a fixed time, then counts clock cycles while the synchronised sensor input stays high, and latches the discharge count. Zero counts are rejected, long discharges saturate, and a per-channel touch flag is produced. Sits between the sense pins and the game logic, one channel per mole pad.

Parameters:
NUM_CH, 4, number of independent sense channels
COUNT_W, 16, width of discharge counter and latched count
CHARGE_CYCLES, 1000, clock cycles charge_out is held high per scan (≥1)
SYNC_STAGES, 2, flops in the sensor_in synchroniser (≥2)
BASE_SHIFT, 3, baseline filter shift, used only with the optional feature

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins one scan of all channels
threshold  in  COUNT_W  touch threshold (absolute, or delta over baseline with the optional feature)
sensor_in  in  NUM_CH  raw sense pin levels (asynchronous)
charge_out  out  NUM_CH  drives sense capacitors high during CHARGE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when every channel has finished
final_count  out  NUM_CH*COUNT_W  latched counts; channel i at [i*COUNT_W +: COUNT_W]
valid  out  NUM_CH  channel has latched at least one non-zero count since reset
touched  out  NUM_CH  registered touch decision per channel
timeout  out  NUM_CH  last scan saturated on that channel

Behaviour:
- Reset (synchronous, clock edge with reset=1): all FSMs to IDLE; charge_out, busy, done, final_count, valid, touched, timeout all 0; synchronisers cleared. Reset mid-scan aborts immediately; no latch occurs.
- Top FSM: IDLE -> SCAN on start=1 (busy=1 next cycle); SCAN -> IDLE when all channels report finished, with done=1 for exactly that one cycle and busy=0 in the same cycle. start while busy is ignored. start on the done cycle is accepted.
- Channel FSM (all channels in lockstep entry, independent exit): IDLE -> CHARGE on scan launch; CHARGE holds charge_out=1 for exactly CHARGE_CYCLES cycles, counter cleared; -> MEASURE with charge_out=0; -> FIN on termination; FIN holds until top returns to IDLE.
- MEASURE uses the synchronised sensor (latency SYNC_STAGES cycles). Each cycle with sync=1: count+1. First cycle with sync=0 terminates:
  - count≠0: final_count←count, valid←1, timeout←0, touched updated.
  - count=0: final_count, valid, touched unchanged (spurious sample rejected); timeout←0.
- Saturation: when count reaches 2^COUNT_W−1 with sync still 1, terminate: final_count←all-ones, timeout←1, valid←1, touched updated.
- touched (without optional feature) = latched count > threshold, unsigned; equal is not touched. Evaluated with threshold value present on the latch cycle.
- Per-channel outputs change only on that channel's termination cycle.

Optional Feature:
CAP_SENSE_BASELINE_EN. When defined: per-channel baseline register (COUNT_W), reset 0. First accepted count after reset loads baseline directly. Thereafter touched = (count > baseline) && (count − baseline > threshold); when the new decision is not touched, baseline ← baseline + ((count − baseline) >>> BASE_SHIFT) using signed COUNT_W+1 arithmetic; baseline frozen while touched. Zero-rejected scans do not update baseline. When undefined: no baseline storage, absolute threshold compare as above.

Decomposition:
- Shared package cap_sense_pkg: channel state enum (CH_IDLE, CH_CHARGE, CH_MEASURE, CH_FIN), top state enum (IDLE, SCAN), localparam COUNT_MAX function of COUNT_W.
- Sub-module cap_sense_channel: synchroniser, charge timer, counter, latch, touch/baseline logic; instantiated NUM_CH times by generate. Top holds scan FSM, done/busy, output packing.

Test Plan:
- Reset then idle: all outputs 0, start pulse with NUM_CH=4, CHARGE_CYCLES=10 -> charge_out=4'hF for exactly 10 cycles, busy=1 throughout.
- Channel 0 sensor high 50 cycles after charge ends, others 20, threshold=30 -> final_count ch0=50, others=20 (±SYNC_STAGES alignment fixed by bench), touched=4'b0001, one done pulse after slowest channel.
- Channel 2 sensor low at MEASURE entry after a prior count of 40 -> final_count ch2 stays 40, valid[2] stays 1, touched[2] unchanged.
- COUNT_W=8, ch1 sensor stuck high -> final_count ch1=255, timeout[1]=1, scan completes with done.
- Reset asserted in MEASURE -> next cycle charge_out=0, busy=0, final_count=0, no done pulse; start pulse during busy -> ignored, no extra scan.
- With CAP_SENSE_BASELINE_EN, BASE_SHIFT=3, threshold=10: counts 100, 108, 130 -> baseline 100, 101, frozen at 101; touched 0, 0, 1.
